// File: rtl/pcie_32_to_64_axi_pkg.sv
// Shared definitions for the 32->64 AXI-stream packer: FSM states and keep patterns.
package pcie_32_to_64_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_PREPARE  = 3'd2,
        ST_WRITE    = 3'd3,
        ST_FINISHED = 3'd4
    } state_t;

    localparam logic [7:0] KEEP_FULL  = 8'hFF;
    localparam logic [7:0] KEEP_UPPER = 8'hF0;
    localparam logic [7:0] KEEP_NONE  = 8'h00;

    // Byte enables for a drained word: only the closing word may be a half word.
    function automatic logic [7:0] word_keep(input logic is_final, input logic [7:0] keep_last);
        return is_final ? keep_last : KEEP_FULL;
    endfunction

endpackage

// File: rtl/pcie_32_to_64_axi_blk_mem.sv
// Simple dual-port block RAM: port A synchronous write, port B registered read.
module pcie_32_to_64_axi_blk_mem #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     wea,
    input  logic [ADDRESS_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0]    dina,
    input  logic [ADDRESS_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0]    doutb
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    always_ff @(posedge clk) begin
        if (wea) begin
            mem[addra] <= dina;
        end
        doutb <= mem[addrb];
    end

endmodule

// File: rtl/pcie_32_to_64_axi.sv
// Store-and-forward packer: 32-bit beats are paired into 64-bit words in block RAM,
// then the whole packet is replayed on the 64-bit side without mid-packet stalls.
module pcie_32_to_64_axi
    import pcie_32_to_64_axi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_32_data,
    input  logic        i_32_valid,
    input  logic        i_32_last,
    output logic        o_32_ready,
    output logic [63:0] o_64_data,
    output logic [7:0]  o_64_keep,
    output logic        o_64_valid,
    output logic        o_64_last,
    input  logic        i_64_ready,
    output logic        o_overflow
);

    // state       | meaning
    // ST_IDLE     | waiting for the first beat of a packet
    // ST_READ     | accepting beats, pairing them into RAM words
    // ST_PREPARE  | input closed, RAM read of word 0 in flight
    // ST_WRITE    | presenting buffered words downstream
    // ST_FINISHED | one idle cycle before the next packet

    localparam int                 DEPTH     = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] LAST_SLOT = (ADDRESS_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH:0] ONE_WORD  = (ADDRESS_WIDTH+1)'(1);

    state_t                   state;
    logic [ADDRESS_WIDTH:0]   r_addr_in;
    logic [ADDRESS_WIDTH:0]   r_addr_out;
    logic [31:0]              upper;
    logic                     half;
    logic [7:0]               keep_last;

    logic                     in_fire;
    logic                     out_fire;
    logic                     accepting;
    logic                     wea;
    logic [63:0]              wr_data;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [ADDRESS_WIDTH:0]   next_out;
    logic [ADDRESS_WIDTH:0]   final_idx;
    logic [63:0]              ram_dout;

    assign accepting = (state == ST_IDLE) || (state == ST_READ);
    assign in_fire   = i_32_valid && o_32_ready && accepting;
    assign out_fire  = o_64_valid && i_64_ready;
    assign next_out  = r_addr_out + 1'b1;
    assign final_idx = r_addr_in - 1'b1;

    // A word is written on every odd beat, and on a last beat that has no partner.
    always_comb begin
        wea     = 1'b0;
        wr_data = {upper, i_32_data};
        if (in_fire) begin
            if (half) begin
                wea     = 1'b1;
                wr_data = {upper, i_32_data};
            end else if (i_32_last) begin
                wea     = 1'b1;
                wr_data = {i_32_data, 32'h0};
            end
        end
    end

    // Port B follows the drain pointer; on a handshake it already looks one word ahead.
    assign rd_addr = out_fire ? next_out[ADDRESS_WIDTH-1:0] : r_addr_out[ADDRESS_WIDTH-1:0];

    pcie_32_to_64_axi_blk_mem #(
        .DATA_WIDTH    (64),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_mem (
        .clk   (clk),
        .wea   (wea),
        .addra (r_addr_in[ADDRESS_WIDTH-1:0]),
        .dina  (wr_data),
        .addrb (rd_addr),
        .doutb (ram_dout)
    );

    assign o_64_data = o_64_valid ? ram_dout : 64'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            r_addr_in  <= '0;
            r_addr_out <= '0;
            upper      <= '0;
            half       <= 1'b0;
            keep_last  <= KEEP_NONE;
            o_32_ready <= 1'b0;
            o_64_keep  <= KEEP_NONE;
            o_64_valid <= 1'b0;
            o_64_last  <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= 1'b0;
            case (state)
                ST_IDLE, ST_READ: begin
                    o_32_ready <= 1'b1;
                    if (in_fire) begin
                        state <= ST_READ;
                        if (wea) begin
                            r_addr_in <= r_addr_in + 1'b1;
                        end
                        if (i_32_last) begin
                            keep_last  <= half ? KEEP_FULL : KEEP_UPPER;
                            half       <= 1'b0;
                            o_32_ready <= 1'b0;
                            state      <= ST_PREPARE;
                        end else if (half && (r_addr_in == LAST_SLOT)) begin
                            // Buffer full without a last beat: close the packet here.
                            keep_last  <= KEEP_FULL;
                            half       <= 1'b0;
                            o_32_ready <= 1'b0;
                            o_overflow <= 1'b1;
                            state      <= ST_PREPARE;
                        end else begin
                            half <= ~half;
                            if (!half) begin
                                upper <= i_32_data;
                            end
                        end
                    end
                end
                ST_PREPARE: begin
                    o_32_ready <= 1'b0;
                    o_64_valid <= 1'b1;
                    o_64_last  <= (r_addr_in == ONE_WORD);
                    o_64_keep  <= word_keep(r_addr_in == ONE_WORD, keep_last);
                    state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (out_fire) begin
                        if (o_64_last) begin
                            o_64_valid <= 1'b0;
                            o_64_last  <= 1'b0;
                            o_64_keep  <= KEEP_NONE;
                            state      <= ST_FINISHED;
                        end else begin
                            r_addr_out <= next_out;
                            o_64_last  <= (next_out == final_idx);
                            o_64_keep  <= word_keep(next_out == final_idx, keep_last);
                        end
                    end
                end
                ST_FINISHED: begin
                    r_addr_in  <= '0;
                    r_addr_out <= '0;
                    o_32_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_32_to_64_axi.sv
// Randomized scoreboard bench for the 32->64 packer against a beat-list reference model.
module tb_pcie_32_to_64_axi;

    localparam int AW    = 6;
    localparam int BEATS = 2 * (2**AW);

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_32_data = '0;
    logic        i_32_valid = 1'b0;
    logic        i_32_last = 1'b0;
    logic        o_32_ready;
    logic [63:0] o_64_data;
    logic [7:0]  o_64_keep;
    logic        o_64_valid;
    logic        o_64_last;
    logic        i_64_ready;
    logic        o_overflow;

    int vectors = 0;
    int miscompares = 0;
    int ready_mode = 0;
    int exp_ovf = 0;
    int ovf_seen = 0;

    word_t       expq[$];
    logic [31:0] pend[$];

    pcie_32_to_64_axi #(.ADDRESS_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_32_data  (i_32_data),
        .i_32_valid (i_32_valid),
        .i_32_last  (i_32_last),
        .o_32_ready (o_32_ready),
        .o_64_data  (o_64_data),
        .o_64_keep  (o_64_keep),
        .o_64_valid (o_64_valid),
        .o_64_last  (o_64_last),
        .i_64_ready (i_64_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: a packet closes on last or at buffer capacity; beats pair up in order.
    task automatic model_beat(input logic [31:0] d, input logic l);
        pend.push_back(d);
        if (l || pend.size() == BEATS) begin
            if (!l) exp_ovf++;
            for (int i = 0; i < pend.size(); i += 2) begin
                word_t w;
                if (i + 1 < pend.size()) begin
                    w.data = {pend[i], pend[i+1]};
                    w.keep = 8'hFF;
                end else begin
                    w.data = {pend[i], 32'h0};
                    w.keep = 8'hF0;
                end
                w.last = (i + 2 >= pend.size());
                expq.push_back(w);
            end
            pend.delete();
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n = 0;
        i_32_data  = d;
        i_32_last  = l;
        i_32_valid = 1'b1;
        @(negedge clk);
        while (!o_32_ready) begin
            n++;
            if (n > 5000) begin
                $display("FAIL input_ready_timeout: o_32_ready stayed 0");
                $fatal(1, "input stalled");
            end
            @(negedge clk);
        end
        @(posedge clk);
        model_beat(d, l);
        #1;
        i_32_valid = 1'b0;
        i_32_last  = 1'b0;
    endtask

    task automatic send_packet(input int len, input logic [31:0] base, input bit rnd,
                               input bit gaps, input bit lat_check);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_beat(rnd ? $urandom() : base + i, i == len - 1);
        end
        if (lat_check) begin
            @(negedge clk);
            check("latency_prepare_valid", 73'(o_64_valid), 73'(0));
            @(negedge clk);
            check("latency_first_valid", 73'(o_64_valid), 73'(1));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || o_64_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) fail_now("drain_timeout");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},    73'(o_32_ready), 73'(0));
        check({tag, "_valid"},    73'(o_64_valid), 73'(0));
        check({tag, "_data"},     73'(o_64_data),  73'(0));
        check({tag, "_keep"},     73'(o_64_keep),  73'(0));
        check({tag, "_last"},     73'(o_64_last),  73'(0));
        check({tag, "_overflow"}, 73'(o_overflow), 73'(0));
    endtask

    initial begin
        int ph = 0;
        i_64_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       i_64_ready = 1'b1;
                1:       i_64_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    i_64_ready = (ph == 0 || ph == 3);
                    ph = (ph + 1) % 4;
                end
                default: i_64_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks hold-stability and no mid-packet gaps.
    initial begin
        word_t w;
        word_t held;
        bit    held_v = 0;
        bit    cont = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 0;
                cont   = 0;
            end else begin
                if (o_overflow) ovf_seen++;
                if (held_v) check("hold_stable", {o_64_valid, o_64_last, o_64_keep, o_64_data},
                                  {1'b1, held.last, held.keep, held.data});
                if (cont) check("no_mid_packet_gap", 73'(o_64_valid), 73'(1));
                held_v = 0;
                cont   = 0;
                if (o_64_valid && i_64_ready) begin
                    if (expq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_word: got %h with empty scoreboard", o_64_data);
                    end else begin
                        w = expq.pop_front();
                        check("word", {o_64_last, o_64_keep, o_64_data}, w);
                    end
                    cont = !o_64_last;
                end else if (o_64_valid) begin
                    held   = {o_64_last, o_64_keep, o_64_data};
                    held_v = 1;
                end
            end
        end
    end

    initial begin
        int n;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        ready_mode = 0;
        send_packet(4, 32'hA000_0000, 0, 0, 1);
        send_packet(3, 32'hB000_0000, 0, 0, 1);
        send_packet(1, 32'hC000_0000, 0, 0, 1);
        drain();
        ready_mode = 2;
        send_packet(4, 32'hA100_0000, 0, 0, 0);
        drain();
        ready_mode = 0;
        send_packet(130, 32'h5000_0000, 0, 0, 0);
        drain();
        check("overflow_after_130_beats", 73'(ovf_seen), 73'(exp_ovf));

        for (int p = 0; p < 20; p++) begin
            ready_mode = $urandom_range(0, 2);
            send_packet($urandom_range(1, 140), 32'h0, 1, 1, 0);
        end
        drain();

        ready_mode = 3;
        send_packet(6, 32'hE000_0000, 0, 0, 0);
        n = 0;
        while (!o_64_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("write_state_timeout");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        expq.delete();
        #1;
        check_outputs_zero("midwrite_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        send_packet(2, 32'hD000_0000, 0, 0, 1);
        drain();

        check("scoreboard_empty", 73'(expq.size()), 73'(0));
        check("overflow_count", 73'(ovf_seen), 73'(exp_ovf));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
